// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control path.
// The enum encodings match the datapath mux wiring, so they must stay fixed.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        BRANCH,
        HALT
    } ctrl_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_RS1    = 2'd2
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_sel_t;

    typedef enum logic [1:0] {
        RES_ALU_REG  = 2'd0,
        RES_MEM_DATA = 2'd1,
        RES_ALU_LIVE = 2'd2
    } result_src_t;

    // States that sit on the memory handshake and are covered by the timeout.
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3 / funct7[5] to an ALU operation for R-type and I-type ALU instructions.
// Flags encodings the datapath does not implement (sltu/sltiu, sra/srai).
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output alu_op_t    alu_op,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct3)
            3'b000: alu_op = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b111: alu_op = ALU_AND;
            3'b110: alu_op = ALU_OR;
            3'b100: alu_op = ALU_XOR;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b101: begin
                alu_op  = ALU_SRL;
                illegal = funct7_b5;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake, halting on illegal ops or timeout.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_sel,
    output logic [2:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        retire,
    output logic        halted
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ctrl_state_t      state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_rtype;
    alu_op_t    dec_op;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_b5         = instr[30];
    assign is_rtype          = (opcode == OP_R);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .is_rtype  (is_rtype),
        .alu_op    (dec_op),
        .illegal   (dec_illegal)
    );

    // The counter never passes TIMEOUT_CYCLES-1: that value without ready forces HALT.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (is_wait_state(state) && (TIMEOUT_CYCLES != 0)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        imm_sel    = IMM_I;
        alu_op     = ALU_ADD;
        result_src = RES_ALU_REG;
        retire     = 1'b0;
        halted     = 1'b0;

        // Reset aborts in-flight accesses: everything stays at its idle default.
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRC_A_PC;
                    alu_src_b  = SRC_B_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALU_LIVE;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end else if (timed_out) begin
                        state_next = HALT;
                    end
                end

                DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    imm_sel   = IMM_B;
                    alu_op    = ALU_ADD;
                    case (opcode)
                        OP_R:               state_next = EXEC_R;
                        OP_I:               state_next = EXEC_I;
                        OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
                        OP_BRANCH:          state_next = BRANCH;
                        default:            state_next = HALT;
                    endcase
                end

                EXEC_R: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    alu_op     = dec_op;
                    state_next = dec_illegal ? HALT : ALU_WB;
                end

                EXEC_I: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    imm_sel    = IMM_I;
                    alu_op     = dec_op;
                    state_next = dec_illegal ? HALT : ALU_WB;
                end

                ALU_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALU_REG;
                    retire     = 1'b1;
                    state_next = FETCH;
                end

                MEM_ADDR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    alu_op    = ALU_ADD;
                    if (funct3 != 3'b010) begin
                        state_next = HALT;
                    end else begin
                        state_next = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
                    end
                end

                MEM_READ: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    if (mem_ready) begin
                        state_next = MEM_WB;
                    end else if (timed_out) begin
                        state_next = HALT;
                    end
                end

                MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM_DATA;
                    retire     = 1'b1;
                    state_next = FETCH;
                end

                MEM_WRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_src = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else if (timed_out) begin
                        state_next = HALT;
                    end
                end

                BRANCH: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    alu_op     = ALU_SUB;
                    result_src = RES_ALU_REG;
                    case (funct3)
                        3'b000: begin
                            pc_write   = alu_zero;
                            retire     = 1'b1;
                            state_next = FETCH;
                        end
                        3'b001: begin
                            pc_write   = !alu_zero;
                            retire     = 1'b1;
                            state_next = FETCH;
                        end
                        default: state_next = HALT;
                    endcase
                end

                HALT: begin
                    halted = 1'b1;
                end

                default: state_next = HALT;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM sequencing the RV32I datapath (pc, register_file, alu, sign_extend, shared instruction/data memory) as a multi-cycle machine.
- Supports: R-type ALU, I-type ALU, lw, sw, beq/bne.
- Drives all enables and mux selects; waits on a ready handshake from memory.
- Halts on illegal instructions or memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ready before halting; 0 disables the timeout.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
instr  input  32  contents of the instruction register.
alu_zero  input  1  ALU result == 0.
mem_ready  input  1  memory completes the transfer this cycle.
mem_req  output  1  memory access request.
mem_we  output  1  write (1) / read (0); valid with mem_req.
addr_src  output  1  memory address: 0 = pc, 1 = ALU result register.
ir_write  output  1  load the instruction register; also latches old_pc.
pc_write  output  1  load pc from result mux.
reg_write  output  1  register_file write_enable.
alu_src_a  output  2  0 = pc, 1 = old_pc, 2 = rs1 data.
alu_src_b  output  2  0 = rs2 data, 1 = immediate, 2 = constant 4.
imm_sel  output  2  0 = I-format, 1 = S-format, 2 = B-format.
alu_op  output  3  alu_op_t: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLL = 5, SRL = 6, SLT = 7.
result_src  output  2  0 = ALU result register, 1 = memory data register, 2 = live ALU output.
retire  output  1  one-cycle pulse when an instruction completes.
halted  output  1  high in HALT.

Behaviour:
- Outputs are combinational from state and instr (Moore style, plus a decode term). All outputs are 0 while rst is high.
- Reset enters FETCH on the next edge.
- rst mid-operation aborts any access immediately; no enable asserts in the reset cycle.
- Memory handshake:
  - Transfer completes in a cycle where mem_req && mem_ready.
  - mem_req, mem_we and addr_src hold stable until then.
  - mem_ready without mem_req is ignored.
- Timeout: wait counter clears on entry to every wait state. On reaching TIMEOUT_CYCLES without ready, go to HALT.
- FETCH: mem_req, addr_src = 0, alu_src_a = 0, alu_src_b = 2, alu_op = ADD, result_src = 2.
  - On ready: ir_write = 1, pc_write = 1 (pc <- pc + 4), go to DECODE.
- DECODE: alu_src_a = 1, alu_src_b = 1, imm_sel = 2, alu_op = ADD (branch target latched). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - anything else -> HALT
- EXEC_R: alu_src_a = 2, alu_src_b = 0, alu_op from alu_decoder -> ALU_WB.
- EXEC_I: alu_src_a = 2, alu_src_b = 1, imm_sel = 0, alu_op from alu_decoder -> ALU_WB.
- ALU_WB: reg_write = 1, result_src = 0, retire -> FETCH.
- MEM_ADDR: alu_src_a = 2, alu_src_b = 1, imm_sel = 0 for load / 1 for store, alu_op = ADD.
  - funct3 != 010 -> HALT; else load -> MEM_READ, store -> MEM_WRITE.
- MEM_READ: mem_req, addr_src = 1; on ready -> MEM_WB.
- MEM_WB: reg_write = 1, result_src = 1, retire -> FETCH.
- MEM_WRITE: mem_req, mem_we, addr_src = 1; on ready retire -> FETCH.
- BRANCH: alu_src_a = 2, alu_src_b = 0, alu_op = SUB, result_src = 0.
  - pc_write = alu_zero for beq (funct3 000), = !alu_zero for bne (funct3 001); other funct3 -> HALT.
  - retire; -> FETCH.
- alu_decoder (funct3 / funct7[5]):
  - 000 -> ADD; SUB only when R-type and funct7[5] = 1.
  - 111 -> AND, 110 -> OR, 100 -> XOR, 001 -> SLL, 010 -> SLT.
  - 101 -> SRL; funct7[5] = 1 is illegal.
  - 011 is illegal.
  - Illegal in EXEC_R/EXEC_I -> HALT with no writes.
- rd = x0 writes still assert reg_write; the register file ignores them.
- HALT: halted = 1, all enables 0; exits only via rst.
- Latency with zero-wait memory: R/I = 4 cycles, lw = 5, sw = 4, branch = 3.

Decomposition:
- Package cpu_ctrl_pkg:
  - alu_op_t (moved out of the cpu file, same encoding);
  - ctrl_state_t (FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, HALT);
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - select enums for alu_src_a, alu_src_b, imm_sel, result_src.
- One sub-module: alu_decoder (combinational: funct3, funct7[5], is_rtype -> alu_op, illegal).

Test Plan:
- rst high 2 cycles, then low, mem_ready = 1, instr = 0x005303b3 (add x7, x6, x5) -> FETCH, DECODE, EXEC_R (alu_op = ADD), ALU_WB with reg_write = 1 and retire = 1 on cycle 4; back in FETCH.
- instr = 0x40530333 (sub x6, x6, x5) -> EXEC_R alu_op = SUB. instr = 0x00533393 (sltiu, funct3 011) -> HALT, halted = 1, no reg_write.
- lw x1, 8(x2) = 0x00812083 with mem_ready low 3 cycles in MEM_READ -> mem_req, addr_src = 1 held for 4 cycles, then MEM_WB with result_src = 1; retire after 8 total cycles.
- beq with alu_zero = 1 -> pc_write = 1 in BRANCH. Same instr with alu_zero = 0 -> pc_write = 0. Both retire in cycle 3.
- TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH -> HALT after 4 cycles. rst asserted later -> FETCH, halted = 0.
- sw asserting rst in MEM_WRITE -> mem_req drops in the reset cycle, no retire; restart in FETCH.
